// File: rtl/jacobi_sweep_ctrl_if.sv
// Rotation request/completion channel between the sweep controller and the 2x2 rotation datapath.
// Request side is valid/ready; completion side is a single-cycle done pulse with a skip qualifier.
// Controller drives the request; the datapath drives ready, done and skip.
interface jacobi_sweep_ctrl_if #(
   parameter int IDX_W = 3
);
   logic             rot_req_valid;
   logic             rot_req_ready;
   logic [IDX_W-1:0] rot_p;
   logic [IDX_W-1:0] rot_q;
   logic             rot_done;
   logic             rot_skip;

   modport master (
      output rot_req_valid, rot_p, rot_q,
      input  rot_req_ready, rot_done, rot_skip
   );

   modport slave (
      input  rot_req_valid, rot_p, rot_q,
      output rot_req_ready, rot_done, rot_skip
   );
endinterface

// File: rtl/jacobi_sweep_ctrl.sv
// One-sided Jacobi sweep controller: walks column pairs row-cyclically, one rotation at a time.
// Latency: minimum 3 cycles per rotation (ISSUE, WAIT, NEXT); done pulses one cycle after the last NEXT.
// Backpressure: request held stable until rot_req_ready; WAIT stalls indefinitely until rot_done.
module jacobi_sweep_ctrl #(
   parameter int N_COLS = 4,
   parameter int IDX_W  = 3
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                start,
   input  logic [3:0]          max_sweeps,
   jacobi_sweep_ctrl_if.master rot,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic [3:0]          sweep_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      NEXT,
      FINISH
   } state_t;

   localparam logic [IDX_W-1:0] P_LAST = IDX_W'(N_COLS - 2);
   localparam logic [IDX_W-1:0] Q_LAST = IDX_W'(N_COLS - 1);

   state_t     state;
   logic       quiet;      // every rotation of the current sweep was skipped
   logic [3:0] limit;      // sweep limit captured at start, zero promoted to one
   logic [3:0] cnt_inc;    // saturating next sweep count
   logic       last_pair;

   assign cnt_inc   = (sweep_cnt == 4'hF) ? 4'hF : sweep_cnt + 4'd1;
   assign last_pair = (rot.rot_p == P_LAST) && (rot.rot_q == Q_LAST);

   // Controller FSM; all outputs are registered and set on entry to the state that owns them.
   // The quiet flag starts cleared for the first sweep, so convergence can only be
   // declared from the second sweep onward.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state             <= IDLE;
         rot.rot_req_valid <= 1'b0;
         rot.rot_p         <= '0;
         rot.rot_q         <= IDX_W'(1);
         busy              <= 1'b0;
         done              <= 1'b0;
         converged         <= 1'b0;
         sweep_cnt         <= 4'd0;
         quiet             <= 1'b0;
         limit             <= 4'd1;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state             <= ISSUE;
                  rot.rot_p         <= '0;
                  rot.rot_q         <= IDX_W'(1);
                  rot.rot_req_valid <= 1'b1;
                  busy              <= 1'b1;
                  sweep_cnt         <= 4'd0;
                  quiet             <= 1'b0;
                  converged         <= 1'b0;
                  limit             <= (max_sweeps == 4'd0) ? 4'd1 : max_sweeps;
               end
            end
            ISSUE: begin
               if (rot.rot_req_ready) begin
                  rot.rot_req_valid <= 1'b0;
                  state             <= WAIT;
               end
            end
            WAIT: begin
               if (rot.rot_done) begin
                  quiet <= quiet & rot.rot_skip;
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (!last_pair) begin
                  if (rot.rot_q == Q_LAST) begin
                     rot.rot_p <= rot.rot_p + IDX_W'(1);
                     rot.rot_q <= rot.rot_p + IDX_W'(2);
                  end else begin
                     rot.rot_q <= rot.rot_q + IDX_W'(1);
                  end
                  rot.rot_req_valid <= 1'b1;
                  state             <= ISSUE;
               end else begin
                  sweep_cnt <= cnt_inc;
                  if (quiet || (cnt_inc == limit)) begin
                     converged <= quiet;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= FINISH;
                  end else begin
                     rot.rot_p         <= '0;
                     rot.rot_q         <= IDX_W'(1);
                     quiet             <= 1'b1;
                     rot.rot_req_valid <= 1'b1;
                     state             <= ISSUE;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state             <= IDLE;
               rot.rot_req_valid <= 1'b0;
               busy              <= 1'b0;
               done              <= 1'b0;
            end
         endcase
      end
   end

endmodule
